// File: rtl/gshare_pkg.sv
// Shared encodings for the gshare predictor: indexing modes, FSM states, counter init value.
// Pure definitions; no latency or flow control of its own.
package gshare_pkg;

    localparam logic [1:0] MODE_BIMODAL = 2'b00;
    localparam logic [1:0] MODE_GSELECT = 2'b01;
    localparam logic [1:0] MODE_GSHARE  = 2'b10;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Weakly not-taken: just below the taken threshold.
    function automatic int ctr_init(input int ctr_w);
        return (1 << (ctr_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/gshare_index.sv
// Pattern-table index from (pc, ghr, mode); bimodal, gselect or gshare (mode 11 = gshare).
// Purely combinational, zero latency, no flow control.
module gshare_index
    import gshare_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int IDX_W  = 8,
    parameter int HIST_W = 8
) (
    input  logic [PC_W-1:0]   pc,
    input  logic [HIST_W-1:0] ghr,
    input  logic [1:0]        mode,
    output logic [IDX_W-1:0]  idx
);

    localparam int H2 = IDX_W / 2;

    always_comb begin
        idx = pc[IDX_W-1:0] ^ IDX_W'(ghr);
        case (mode)
            MODE_BIMODAL: idx = pc[IDX_W-1:0];
            MODE_GSELECT: idx = {pc[IDX_W-H2-1:0], ghr[H2-1:0]};
            default:      idx = pc[IDX_W-1:0] ^ IDX_W'(ghr);
        endcase
    end

endmodule

// File: rtl/gshare_param_predictor.sv
// Global-history branch predictor with sweep-initialised saturating-counter table and stats.
// Prediction registered one cycle after accept; br_ready low while the table sweep runs.
module gshare_param_predictor
    import gshare_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int IDX_W  = 8,
    parameter int HIST_W = 8,
    parameter int CTR_W  = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [PC_W-1:0]   br_pc,
    input  logic              br_taken,
    input  logic [1:0]        mode,
    input  logic              ghr_clear,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic              pred_correct,
    output logic [HIST_W-1:0] ghr,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  mispredict_count
);

    localparam int               TBL_D   = 2 ** IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_INI = CTR_W'(ctr_init(CTR_W));
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CTR_W-1:0]   tbl_q [TBL_D];
    logic [HIST_W-1:0]  ghr_q, ghr_d;
    logic [CNT_W-1:0]   bcnt_q, bcnt_d, mcnt_q, mcnt_d;
    logic               pvld_q, pvld_d, ptkn_q, ptkn_d, pcor_q, pcor_d;

    logic               accept, pred, miss, wr_en;
    logic [IDX_W-1:0]   idx, wr_idx;
    logic [CTR_W-1:0]   ctr_rd, wr_val;

    gshare_index #(.PC_W(PC_W), .IDX_W(IDX_W), .HIST_W(HIST_W)) u_index (
        .pc   (br_pc),
        .ghr  (ghr_q),
        .mode (mode),
        .idx  (idx)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && ptr_q == IDX_W'(TBL_D - 1)) state_d = ST_RUN;
    end

    always_comb begin
        br_ready = (state_q == ST_RUN);
    end

    assign accept = br_valid & br_ready;
    assign ctr_rd = tbl_q[idx];
    assign pred   = ctr_rd[CTR_W-1];
    assign miss   = pred ^ br_taken;

    always_comb begin
        ptr_d  = ptr_q;
        wr_en  = 1'b0;
        wr_idx = idx;
        wr_val = ctr_rd;
        if (state_q == ST_INIT) begin
            wr_en  = 1'b1;
            wr_idx = ptr_q;
            wr_val = CTR_INI;
            ptr_d  = ptr_q + IDX_W'(1);
        end else if (accept) begin
            wr_en = 1'b1;
            if (br_taken) wr_val = (ctr_rd == CTR_MAX) ? ctr_rd : ctr_rd + CTR_W'(1);
            else          wr_val = (ctr_rd == '0)      ? ctr_rd : ctr_rd - CTR_W'(1);
        end
    end

    // Clear wins over the shift; the accepted branch has already indexed with the old history.
    always_comb begin
        ghr_d  = ghr_q;
        bcnt_d = bcnt_q;
        mcnt_d = mcnt_q;
        pvld_d = accept;
        ptkn_d = accept & pred;
        pcor_d = accept & ~miss;
        if (accept) begin
            ghr_d = {ghr_q[HIST_W-2:0], br_taken};
            if (bcnt_q != CNT_MAX)         bcnt_d = bcnt_q + CNT_W'(1);
            if (miss && mcnt_q != CNT_MAX) mcnt_d = mcnt_q + CNT_W'(1);
        end
        if (ghr_clear) ghr_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= '0;
            ghr_q  <= '0;
            bcnt_q <= '0;
            mcnt_q <= '0;
            pvld_q <= 1'b0;
            ptkn_q <= 1'b0;
            pcor_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            ghr_q  <= ghr_d;
            bcnt_q <= bcnt_d;
            mcnt_q <= mcnt_d;
            pvld_q <= pvld_d;
            ptkn_q <= ptkn_d;
            pcor_q <= pcor_d;
        end
    end

    // Table contents need no reset: the INIT sweep rewrites every entry.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) tbl_q[wr_idx] <= wr_val;
    end

    assign pred_valid       = pvld_q;
    assign pred_taken       = ptkn_q;
    assign pred_correct     = pcor_q;
    assign ghr              = ghr_q;
    assign branch_count     = bcnt_q;
    assign mispredict_count = mcnt_q;

endmodule

// File: tb/tb_gshare_param_predictor.sv
// Directed bench for gshare_param_predictor (default and CNT_W=4 instances) and gshare_index.
// Inputs driven 1 time unit after the rising edge; outputs sampled there too.
module tb_gshare_param_predictor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       br_valid = 1'b0;
    logic [7:0] br_pc = '0;
    logic       br_taken = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       ghr_clear = 1'b0;

    logic        br_ready, pred_valid, pred_taken, pred_correct;
    logic [7:0]  ghr;
    logic [31:0] branch_count, mispredict_count;

    logic        d4_br_ready, d4_pred_valid, d4_pred_taken, d4_pred_correct;
    logic [7:0]  d4_ghr;
    logic [3:0]  d4_branch_count, d4_mispredict_count;

    logic [7:0] u_pc, u_ghr, u_idx;
    logic [1:0] u_mode;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gshare_param_predictor dut (
        .clk(clk), .reset(reset), .br_valid(br_valid), .br_ready(br_ready),
        .br_pc(br_pc), .br_taken(br_taken), .mode(mode), .ghr_clear(ghr_clear),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_correct(pred_correct),
        .ghr(ghr), .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    gshare_param_predictor #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .br_valid(br_valid), .br_ready(d4_br_ready),
        .br_pc(br_pc), .br_taken(br_taken), .mode(mode), .ghr_clear(ghr_clear),
        .pred_valid(d4_pred_valid), .pred_taken(d4_pred_taken), .pred_correct(d4_pred_correct),
        .ghr(d4_ghr), .branch_count(d4_branch_count), .mispredict_count(d4_mispredict_count)
    );

    gshare_index u_idx_dut (.pc(u_pc), .ghr(u_ghr), .mode(u_mode), .idx(u_idx));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic branch(input logic [7:0] pc, input logic tk, input logic [1:0] md,
                          input logic clr);
        br_valid  = 1'b1;
        br_pc     = pc;
        br_taken  = tk;
        mode      = md;
        ghr_clear = clr;
        @(posedge clk); #1;
        br_valid  = 1'b0;
        ghr_clear = 1'b0;
    endtask

    // Reset, check cleared outputs, then count cycles until br_ready rises (bounded).
    task automatic do_reset(input logic hold_valid, input int n_edges);
        int low_cnt;
        reset    = 1'b1;
        br_valid = hold_valid;
        br_pc    = 8'h33;
        br_taken = 1'b1;
        repeat (n_edges) @(posedge clk);
        #1;
        chk("rst_pred_valid", pred_valid, 0);
        chk("rst_br_ready", br_ready, 0);
        chk("rst_branch_count", branch_count, 0);
        chk("rst_mispredict_count", mispredict_count, 0);
        chk("rst_ghr", ghr, 0);
        reset   = 1'b0;
        low_cnt = 0;
        while (!br_ready && low_cnt < 1000) begin
            @(posedge clk); #1;
            low_cnt++;
        end
        br_valid = 1'b0;
        chk("init_ready_low_cycles", low_cnt, 256);
        chk("init_branch_count", branch_count, 0);
    endtask

    initial begin
        int bad_ent;
        int miss50;

        // gshare_index unit vectors
        u_pc = 8'h3C; u_ghr = 8'hA5;
        u_mode = 2'b00; #1; chk("idx_bimodal", u_idx, 8'h3C);
        u_mode = 2'b01; #1; chk("idx_gselect", u_idx, 8'hC5);
        u_mode = 2'b10; #1; chk("idx_gshare", u_idx, 8'h99);
        u_mode = 2'b11; #1; chk("idx_mode11", u_idx, 8'h99);
        u_pc = 8'h0F; u_ghr = 8'h3B; u_mode = 2'b01; #1; chk("idx_gselect2", u_idx, 8'hFB);

        // 1. reset and init sweep
        do_reset(1'b0, 2);
        chk("t1_pred_valid", pred_valid, 0);
        bad_ent = 0;
        for (int i = 0; i < 256; i++) if (dut.tbl_q[i] != 2'd1) bad_ent++;
        chk("t1_table_bad_entries", bad_ent, 0);

        // 2. bimodal, always taken: first prediction N, then T
        for (int i = 0; i < 20; i++) begin
            branch(8'h3C, 1'b1, 2'b00, 1'b0);
            chk("t2_pred_valid", pred_valid, 1);
            chk("t2_pred_taken", pred_taken, (i == 0) ? 1'b0 : 1'b1);
        end
        @(posedge clk); #1;
        chk("t2_idle_pred_valid", pred_valid, 0);
        chk("t2_branch_count", branch_count, 20);
        chk("t2_mispredict_count", mispredict_count, 1);
        chk("t2_ghr", ghr, 8'hFF);

        // 3. gshare, alternating T/N from a clean history
        do_reset(1'b0, 2);
        miss50 = 0;
        for (int i = 0; i < 100; i++) begin
            branch(8'h10, (i % 2 == 0), 2'b10, 1'b0);
            if (i < 10) chk("t3_early_correct", pred_correct, (i % 2 == 1));
            if (i >= 50 && !pred_correct) miss50++;
        end
        chk("t3_mispredict_count", mispredict_count, 5);
        chk("t3_last50_misses", miss50, 0);
        chk("t3_branch_count", branch_count, 100);

        // 4. gselect, ghr held at 0 by clear, outcome always opposite the prediction
        do_reset(1'b0, 2);
        for (int i = 0; i < 20; i++) begin
            branch(8'h21, (i % 2 == 0), 2'b01, 1'b1);
            if (i < 4) chk("t4_pred_correct", pred_correct, 0);
            if (i == 15) chk("t4_d4_mis_at16", d4_mispredict_count, 15);
        end
        chk("t4_d4_mispredict_hold", d4_mispredict_count, 15);
        chk("t4_d4_branch_hold", d4_branch_count, 15);
        chk("t4_mispredict_count", mispredict_count, 20);
        chk("t4_ghr", ghr, 0);

        // 5. build ghr = 0xA5, then clear coincident with a taken gshare branch
        do_reset(1'b0, 2);
        branch(8'h00, 1'b1, 2'b00, 1'b0);
        branch(8'h00, 1'b0, 2'b00, 1'b0);
        branch(8'h00, 1'b1, 2'b00, 1'b0);
        branch(8'h00, 1'b0, 2'b00, 1'b0);
        branch(8'h00, 1'b0, 2'b00, 1'b0);
        branch(8'h00, 1'b1, 2'b00, 1'b0);
        branch(8'h00, 1'b0, 2'b00, 1'b0);
        branch(8'h00, 1'b1, 2'b00, 1'b0);
        chk("t5_ghr_a5", ghr, 8'hA5);
        branch(8'h0F, 1'b1, 2'b10, 1'b1);
        chk("t5_ghr_cleared", ghr, 0);
        chk("t5_pred_taken", pred_taken, 0);
        chk("t5_tbl_aa", dut.tbl_q[8'hAA], 2);
        chk("t5_tbl_0f", dut.tbl_q[8'h0F], 1);
        chk("t5_branch_count", branch_count, 9);

        // 6. 30 more branches, then reset mid-run with br_valid held through INIT
        for (int i = 0; i < 30; i++) branch(8'(i), i[0], 2'b10, 1'b0);
        chk("t6_branch_count_pre", branch_count, 39);
        chk("t6_pred_valid_pre", pred_valid, 1);
        do_reset(1'b1, 1);
        chk("t6_pred_valid_post", pred_valid, 0);
        chk("t6_ghr_post", ghr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
